// File: rtl/audio_nios_pio_bidir.sv
// Avalon-MM GPIO slave with per-bit direction, optional open-drain drive,
// atomic set/clear writes, synchronised inputs, edge capture and a masked irq.
module audio_nios_pio_bidir #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2,
  parameter bit               OPEN_DRAIN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [2:0]       warm_cnt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_hit;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign sync         = sync_q[SYNC_STAGES-1];
  assign clr          = (wr && address == 3'd3) ? wdata : '0;
  assign unused_wdata = ^writedata;

  // Edges are masked until the synchroniser has flushed its reset zeros.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = sync & ~prev;
      1:       edge_hit = ~sync & prev;
      default: edge_hit = sync ^ prev;
    endcase
    if (warm_cnt != 3'd0) edge_hit = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev     <= '0;
      warm_cnt <= WARM_INIT;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
      if (warm_cnt != 3'd0) warm_cnt <= warm_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      dir      <= DIR_RESET;
      mask     <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          3'd0:    data_out <= wdata;
          3'd1:    dir      <= wdata;
          3'd2:    mask     <= wdata;
          3'd4:    data_out <= data_out | wdata;
          3'd5:    data_out <= data_out & ~wdata;
          default: ;
        endcase
      end
      // A new edge beats a same-cycle write-1-clear.
      edgecap <= (edgecap & ~clr) | edge_hit;
      irq     <= |(edgecap & mask);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = sync;
      3'd1:    readdata[WIDTH-1:0] = dir;
      3'd2:    readdata[WIDTH-1:0] = mask;
      3'd3:    readdata[WIDTH-1:0] = edgecap;
      3'd4:    readdata[WIDTH-1:0] = data_out;
      default: readdata = '0;
    endcase
  end

  assign pin_out = OPEN_DRAIN ? '0 : data_out;
  assign pin_oe  = OPEN_DRAIN ? (dir & ~data_out) : dir;

endmodule

// File: tb/tb_audio_nios_pio_bidir.sv
// Directed bench for audio_nios_pio_bidir: register table plus edge, irq,
// clear-race, open-drain and reset warm-up sequences.
module tb_audio_nios_pio_bidir;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        cs_main;
  logic        cs_od;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] rd_od;
  logic [7:0]  pin_in;
  logic [7:0]  pin_out, pin_oe, pin_out_od, pin_oe_od;
  logic        irq, irq_od;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_nios_pio_bidir #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hFF),
    .EDGE_TYPE(0), .SYNC_STAGES(2), .OPEN_DRAIN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_main),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  audio_nios_pio_bidir #(
    .WIDTH(8), .OPEN_DRAIN(1'b1)
  ) dut_od (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_od),
    .write_n(write_n), .writedata(writedata), .readdata(rd_od),
    .pin_in(pin_in), .pin_out(pin_out_od), .pin_oe(pin_oe_od), .irq(irq_od)
  );

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic sel_od, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    cs_main   = ~sel_od;
    cs_od     = sel_od;
    write_n   = 1'b0;
    @(posedge clk);
    #1;
    cs_main = 1'b0;
    cs_od   = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'd4, 32'h0F,  3'd4, 32'hAF, 8'hAF, 8'hFF};
    vecs[1]  = '{3'd5, 32'h81,  3'd4, 32'h2E, 8'h2E, 8'hFF};
    vecs[2]  = '{3'd0, 32'h1FF, 3'd4, 32'hFF, 8'hFF, 8'hFF};
    vecs[3]  = '{3'd1, 32'h3C,  3'd1, 32'h3C, 8'hFF, 8'h3C};
    vecs[4]  = '{3'd2, 32'h155, 3'd2, 32'h55, 8'hFF, 8'h3C};
    vecs[5]  = '{3'd6, 32'hFF,  3'd6, 32'h00, 8'hFF, 8'h3C};
    vecs[6]  = '{3'd5, 32'hF0,  3'd5, 32'h00, 8'h0F, 8'h3C};
    vecs[7]  = '{3'd1, 32'hFF,  3'd1, 32'hFF, 8'h0F, 8'hFF};
    vecs[8]  = '{3'd2, 32'h01,  3'd2, 32'h01, 8'h0F, 8'hFF};
    vecs[9]  = '{3'd0, 32'h00,  3'd7, 32'h00, 8'h00, 8'hFF};
    vecs[10] = '{3'd7, 32'hAA,  3'd3, 32'h00, 8'h00, 8'hFF};

    reset = 1'b1; address = 3'd0; cs_main = 1'b0; cs_od = 1'b0;
    write_n = 1'b1; writedata = '0; pin_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    #1;
    check("rst_pin_out", {24'h0, pin_out}, 32'hA5);
    check("rst_pin_oe", {24'h0, pin_oe}, 32'hFF);
    check("rst_irq", {31'h0, irq}, 32'h0);
    address = 3'd1; #1 check("rst_dir", readdata, 32'hFF);
    address = 3'd4; #1 check("rst_data_out", readdata, 32'hA5);
    address = 3'd3; #1 check("rst_edgecap", readdata, 32'h0);

    for (int i = 0; i < 11; i++) begin
      bus_write(1'b0, vecs[i].waddr, vecs[i].wdata);
      address = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), {24'h0, pin_out}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_oe", i), {24'h0, pin_oe}, {24'h0, vecs[i].exp_oe});
    end

    // rising edge on bit 0, mask = 0x01
    @(negedge clk); pin_in = 8'h01; address = 3'd0;
    @(posedge clk); #1 check("sync_lat1", readdata, 32'h0);
    @(posedge clk); #1 check("sync_lat2", readdata, 32'h1);
    address = 3'd3; #1 check("edgecap_pre", readdata, 32'h0);
    @(posedge clk); #1 check("edgecap_set", readdata, 32'h1);
    check("irq_pre", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 check("irq_set", {31'h0, irq}, 32'h1);

    bus_write(1'b0, 3'd3, 32'h01);
    #1 check("edgecap_clr", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("irq_clr", {31'h0, irq}, 32'h0);

    @(negedge clk); pin_in = 8'h00;
    repeat (6) @(posedge clk);
    #1 check("fall_nocap", readdata, 32'h0);
    check("fall_noirq", {31'h0, irq}, 32'h0);
    address = 3'd0; #1 check("fall_sync", readdata, 32'h0);

    // rising edge lands on the same edge as the clear
    @(negedge clk); pin_in = 8'h01;
    @(posedge clk);
    @(posedge clk);
    bus_write(1'b0, 3'd3, 32'h01);
    #1 check("race_edgecap", readdata, 32'h1);
    check("race_irq0", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 check("race_irq1", {31'h0, irq}, 32'h1);
    @(posedge clk); #1 check("race_irq_hold", {31'h0, irq}, 32'h1);
    check("race_edgecap_hold", readdata, 32'h1);

    bus_write(1'b0, 3'd2, 32'h00);
    @(posedge clk); #1 check("mask_off_irq", {31'h0, irq}, 32'h0);
    address = 3'd3; #1 check("mask_off_edgecap", readdata, 32'h1);

    // open-drain instance
    bus_write(1'b1, 3'd1, 32'h03);
    bus_write(1'b1, 3'd0, 32'h01);
    #1 check("od_oe", {24'h0, pin_oe_od}, 32'h02);
    check("od_out", {24'h0, pin_out_od}, 32'h00);
    bus_write(1'b1, 3'd0, 32'h00);
    #1 check("od_oe_low", {24'h0, pin_oe_od}, 32'h03);
    check("od_main_untouched", {24'h0, pin_out}, 32'h00);

    // pins high through reset: warm-up must hide the reset-zero edges
    @(negedge clk); pin_in = 8'hFF; reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 address = 3'd3;
    #1 check("warm_edgecap", readdata, 32'h0);
    check("warm_irq", {31'h0, irq}, 32'h0);
    address = 3'd0; #1 check("warm_sync", readdata, 32'hFF);
    check("warm_pin_out", {24'h0, pin_out}, 32'hA5);

    // reset in the middle of a capture
    bus_write(1'b0, 3'd2, 32'h10);
    @(negedge clk); pin_in = 8'hEF;
    repeat (5) @(posedge clk);
    @(negedge clk); pin_in = 8'hFF;
    repeat (4) @(posedge clk);
    #1 address = 3'd3;
    #1 check("mid_edgecap", readdata, 32'h10);
    check("mid_irq", {31'h0, irq}, 32'h1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_edgecap", readdata, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    address = 3'd2; #1 check("mid_rst_mask", readdata, 32'h0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
